// File: rtl/vx_mem_rsp_pkg.sv
// Shared helpers for the memory response demux: port-index width
// derivation used by the top and anything that builds tags for it.
package vx_mem_rsp_pkg;

  // Number of tag LSBs that carry the requester index.
  function automatic int sel_bits(input int n);
    return (n > 1) ? $clog2(n) : 0;
  endfunction

  // Width of a vector able to hold the index; never zero so it can be declared.
  function automatic int sel_vec_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Tag width left after the index bits are stripped off.
  function automatic int out_tag_width(input int tag_w, input int n);
    return tag_w - sel_bits(n);
  endfunction

endpackage

// File: rtl/vx_rsp_elastic_buf2.sv
// Generic 2-entry elastic buffer (circular, wr/rd pointer + count).
// Outputs are driven from registers only: in_ready depends on count alone,
// and out_data comes straight out of storage, so no combinational path
// crosses from the input side to the output side or back.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high; the sender holds valid and payload stable until that edge.
module vx_rsp_elastic_buf2 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] mem_q [2];
  logic [WIDTH-1:0] mem_d [2];
  logic             wr_ptr_q;
  logic             wr_ptr_d;
  logic             rd_ptr_q;
  logic             rd_ptr_d;
  logic [1:0]       count_q;
  logic [1:0]       count_d;
  logic             push;
  logic             pop;

  assign in_ready  = (count_q != 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign out_data  = mem_q[rd_ptr_q];
  assign count     = count_q;

  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;

  // Storage write: only the slot at wr_ptr changes, and only on push.
  always_comb begin
    mem_d = mem_q;
    if (push) begin
      mem_d[wr_ptr_q] = in_data;
    end
  end

  // Pointer toggles and occupancy bookkeeping.
  always_comb begin
    wr_ptr_d = wr_ptr_q ^ push;
    rd_ptr_d = rd_ptr_q ^ pop;
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // Control state; reset drops any buffered entries.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // Occupancy can never reach the unused encoding.
  a_count_range : assert property (@(posedge clk) disable iff (!reset)
    count_q != 2'd3);

  // With two entries the read and write pointers coincide exactly when empty or full.
  a_ptr_consistent : assert property (@(posedge clk) disable iff (!reset)
    ((count_q == 2'd1) == (wr_ptr_q != rd_ptr_q)));

endmodule

// File: rtl/vx_mem_rsp_demux.sv
// Memory response demux: buffers the single response channel and steers
// each response to the requester named by the low tag bits, forwarding the
// tag with those bits removed. Order is strictly FIFO across all ports, so a
// stalled head blocks responses for every other port.
//
// Handshake: rsp_in transfers on an edge with rsp_in_valid & rsp_in_ready;
// port i transfers on an edge with rsp_out_valid[i] & rsp_out_ready[i].
// Ready on a port whose valid is low has no effect.
module vx_mem_rsp_demux
  import vx_mem_rsp_pkg::*;
#(
  parameter int NUM_REQS   = 4,
  parameter int DATA_WIDTH = 512,
  parameter int TAG_WIDTH  = 8,
  localparam int SEL_BITS      = sel_bits(NUM_REQS),
  localparam int OUT_TAG_WIDTH = out_tag_width(TAG_WIDTH, NUM_REQS)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     rsp_in_valid,
  input  logic [DATA_WIDTH-1:0]    rsp_in_data,
  input  logic [TAG_WIDTH-1:0]     rsp_in_tag,
  output logic                     rsp_in_ready,
  output logic [NUM_REQS-1:0]      rsp_out_valid,
  output logic [DATA_WIDTH-1:0]    rsp_out_data,
  output logic [OUT_TAG_WIDTH-1:0] rsp_out_tag,
  input  logic [NUM_REQS-1:0]      rsp_out_ready,
  output logic [1:0]               occupancy
);

  localparam int SEL_W = sel_vec_width(NUM_REQS);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [TAG_WIDTH-1:0]  tag;
  } entry_t;

  localparam int ENTRY_W = $bits(entry_t);

  entry_t             in_entry;
  entry_t             head_entry;
  logic [ENTRY_W-1:0] head_bits;
  logic               head_valid;
  logic               head_ready;
  logic [SEL_W-1:0]   sel;
  logic               sel_ok;

  assign in_entry.data = rsp_in_data;
  assign in_entry.tag  = rsp_in_tag;
  assign head_entry    = entry_t'(head_bits);

  vx_rsp_elastic_buf2 #(
    .WIDTH (ENTRY_W)
  ) u_buf (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (rsp_in_valid),
    .in_data   (in_entry),
    .in_ready  (rsp_in_ready),
    .out_valid (head_valid),
    .out_data  (head_bits),
    .out_ready (head_ready),
    .count     (occupancy)
  );

  // Port index comes from the head tag LSBs; a single port always uses index 0.
  if (NUM_REQS > 1) begin : g_sel
    assign sel = head_entry.tag[SEL_BITS-1:0];
  end else begin : g_nosel
    assign sel = '0;
  end

  assign sel_ok       = (int'(sel) < NUM_REQS);
  assign rsp_out_data = head_entry.data;
  assign rsp_out_tag  = head_entry.tag[TAG_WIDTH-1:SEL_BITS];

  // One-hot valid toward the selected requester; all low while empty.
  always_comb begin
    rsp_out_valid = '0;
    for (int i = 0; i < NUM_REQS; i++) begin
      rsp_out_valid[i] = head_valid && (int'(sel) == i);
    end
  end

  // Head retires only when the selected port accepts it; an out-of-range
  // index matches no port, so such an entry stays stuck at the head.
  always_comb begin
    head_ready = |(rsp_out_valid & rsp_out_ready);
  end

  // Requester index must name an existing port.
  a_sel_in_range : assert property (@(posedge clk) disable iff (!reset)
    head_valid |-> sel_ok);

  // At most one requester sees valid at a time.
  a_valid_onehot : assert property (@(posedge clk) disable iff (!reset)
    $onehot0(rsp_out_valid));

  // A presented response holds steady until it is taken.
  a_out_stable : assert property (@(posedge clk) disable iff (!reset)
    (head_valid && !head_ready) |=> ($stable(rsp_out_valid) &&
      $stable(rsp_out_data) && $stable(rsp_out_tag)));

endmodule

// File: tb/tb_vx_mem_rsp_demux.sv
// Bench for vx_mem_rsp_demux: directed scenarios plus random traffic, all
// checked by a reference queue model that tracks accepted responses.
module tb_vx_mem_rsp_demux;

  localparam int NR  = 4;
  localparam int DW  = 512;
  localparam int TW  = 8;
  localparam int OTW = 6;
  localparam int EW  = DW + TW;

  logic           clk;
  logic           reset;
  logic           rsp_in_valid;
  logic [DW-1:0]  rsp_in_data;
  logic [TW-1:0]  rsp_in_tag;
  logic           rsp_in_ready;
  logic [NR-1:0]  rsp_out_valid;
  logic [DW-1:0]  rsp_out_data;
  logic [OTW-1:0] rsp_out_tag;
  logic [NR-1:0]  rsp_out_ready;
  logic [1:0]     occupancy;

  int errors = 0;
  int checks = 0;

  // Reference model: responses accepted and not yet delivered, oldest first.
  // Each entry is {data, tag}.
  logic [EW-1:0] exp_q[$];

  vx_mem_rsp_demux #(
    .NUM_REQS   (NR),
    .DATA_WIDTH (DW),
    .TAG_WIDTH  (TW)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .rsp_in_valid  (rsp_in_valid),
    .rsp_in_data   (rsp_in_data),
    .rsp_in_tag    (rsp_in_tag),
    .rsp_in_ready  (rsp_in_ready),
    .rsp_out_valid (rsp_out_valid),
    .rsp_out_data  (rsp_out_data),
    .rsp_out_tag   (rsp_out_tag),
    .rsp_out_ready (rsp_out_ready),
    .occupancy     (occupancy)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] rand_data();
    logic [DW-1:0] d;
    for (int i = 0; i < DW / 32; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  // Scoreboard / monitor: samples on the falling edge, compares DUT outputs
  // against the model, then applies the transfers that the next rising edge
  // will perform.
  logic [NR-1:0] m_exp_valid;
  logic [1:0]    m_sel;
  bit            m_pop;
  bit            m_push;
  always @(negedge clk) begin
    if (!reset) begin
      exp_q.delete();
    end else begin
      chk("in_ready", EW'(rsp_in_ready), EW'(exp_q.size() != 2));
      chk("occupancy", EW'(occupancy), EW'(exp_q.size()));
      m_exp_valid = '0;
      m_pop = 0;
      if (exp_q.size() > 0) begin
        m_sel = exp_q[0][1:0];
        m_exp_valid = NR'(1) << m_sel;
        chk("out_tag", EW'(rsp_out_tag), EW'(exp_q[0][TW-1:2]));
        chk("out_data", EW'(rsp_out_data), EW'(exp_q[0][EW-1:TW]));
        m_pop = rsp_out_ready[m_sel];
      end
      chk("out_valid", EW'(rsp_out_valid), EW'(m_exp_valid));
      m_push = rsp_in_valid && (exp_q.size() != 2);
      if (m_pop) void'(exp_q.pop_front());
      if (m_push) exp_q.push_back({rsp_in_data, rsp_in_tag});
    end
  end

  // Driver: offer one response (called at posedge+1), hold until accepted.
  task automatic offer(input logic [TW-1:0] tag, input logic [DW-1:0] data);
    bit acc;
    acc = 0;
    rsp_in_valid = 1'b1;
    rsp_in_tag   = tag;
    rsp_in_data  = data;
    for (int c = 0; c < 60 && !acc; c++) begin
      @(negedge clk);
      acc = rsp_in_ready;
      @(posedge clk);
      #1;
    end
    rsp_in_valid = 1'b0;
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL offer_timeout tag=%0h: got not accepted expected accepted", tag);
    end
  endtask

  // Let everything out, bounded.
  task automatic drain();
    bit done;
    done = 0;
    rsp_out_ready = '1;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      done = (exp_q.size() == 0);
    end
    chk("drain_done", EW'(done), EW'(1));
    @(posedge clk);
    #1;
  endtask

  bit rand_done;

  initial begin
    reset = 1'b0;
    rsp_in_valid = 1'b0;
    rsp_in_data = '0;
    rsp_in_tag = '0;
    rsp_out_ready = '0;
    rand_done = 0;

    // Reset then idle
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", EW'(rsp_in_ready), EW'(1));
    chk("rst_out_valid", EW'(rsp_out_valid), EW'(4'b0000));
    chk("rst_occupancy", EW'(occupancy), EW'(0));
    @(posedge clk);
    #1;

    // Single routing: tag 2D goes to port 1 as tag 0B
    rsp_out_ready = 4'b0010;
    offer(8'h2D, {16{32'hA5A5_0001}});
    @(negedge clk);
    chk("route_valid", EW'(rsp_out_valid), EW'(4'b0010));
    chk("route_tag", EW'(rsp_out_tag), EW'(6'h0B));
    chk("route_data", EW'(rsp_out_data), EW'({16{32'hA5A5_0001}}));
    @(negedge clk);
    chk("route_occ_after_pop", EW'(occupancy), EW'(0));
    @(posedge clk);
    #1;

    // Back-pressure until full
    rsp_out_ready = '0;
    offer(8'h00, rand_data());
    offer(8'h01, rand_data());
    rsp_in_valid = 1'b1;
    rsp_in_tag = 8'h02;
    rsp_in_data = rand_data();
    repeat (3) begin
      @(negedge clk);
      chk("full_occ", EW'(occupancy), EW'(2));
      chk("full_in_ready", EW'(rsp_in_ready), EW'(0));
    end
    @(posedge clk);
    #1 rsp_out_ready = 4'b0001;
    @(negedge clk);
    chk("full_head_valid", EW'(rsp_out_valid), EW'(4'b0001));
    @(negedge clk);
    chk("full_ready_back", EW'(rsp_in_ready), EW'(1));
    @(posedge clk);
    #1 rsp_in_valid = 1'b0;
    drain();

    // Streaming: 100 back-to-back with all readies high
    rsp_out_ready = '1;
    for (int i = 0; i < 100; i++) offer(8'($urandom), rand_data());
    drain();

    // Head-of-line: port 3 stalled blocks port 0
    rsp_out_ready = 4'b0001;
    offer(8'h13, rand_data());
    offer(8'h20, rand_data());
    repeat (4) begin
      @(negedge clk);
      chk("hol_occ", EW'(occupancy), EW'(2));
      chk("hol_valid", EW'(rsp_out_valid), EW'(4'b1000));
    end
    @(posedge clk);
    #1 rsp_out_ready = 4'b1001;
    @(negedge clk);
    chk("hol_first", EW'(rsp_out_valid), EW'(4'b1000));
    @(negedge clk);
    chk("hol_second", EW'(rsp_out_valid), EW'(4'b0001));
    @(negedge clk);
    chk("hol_empty", EW'(occupancy), EW'(0));
    @(posedge clk);
    #1;

    // Reset mid-operation with two buffered entries
    rsp_out_ready = '0;
    offer(8'h05, rand_data());
    offer(8'h06, rand_data());
    @(negedge clk);
    chk("mid_occ_full", EW'(occupancy), EW'(2));
    @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    chk("mid_valid", EW'(rsp_out_valid), EW'(4'b0000));
    chk("mid_occ", EW'(occupancy), EW'(0));
    chk("mid_in_ready", EW'(rsp_in_ready), EW'(1));
    rsp_out_ready = '1;
    repeat (5) begin
      @(negedge clk);
      chk("mid_no_stale", EW'(rsp_out_valid), EW'(4'b0000));
    end
    @(posedge clk);
    #1;

    // Random traffic with random readiness and gaps
    fork
      begin
        for (int i = 0; i < 150; i++) begin
          repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
          end
          offer(8'($urandom), rand_data());
        end
        rand_done = 1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk);
          #1 rsp_out_ready = NR'($urandom_range(0, 15));
        end
      end
    join
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Watchdog
  initial begin
    #500000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
